// File: rtl/fifo_pkg.sv
// Shared constants and helpers for fifo_sync and its companions.
// Status bus layout: [0] empty, [1] full, [ADDR_WIDTH+1:2] fill.
// Also holds the read-issue budget check used by the reader.
package fifo_pkg;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_FILL_LSB = 2;

    // True when one more read still fits in a 2-entry buffer, counting
    // words already held, the word in flight, and the word leaving now.
    // occ >= pop always holds, so the 3-bit sum never wraps.
    function automatic logic can_issue(input logic [1:0] occ,
                                       input logic       infl,
                                       input logic       pop);
        logic [2:0] sum;
        sum = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        return (sum < 3'd2);
    endfunction

endpackage

// File: rtl/fifo_sync_reader_if.sv
// Downstream word stream of the FIFO reader: valid/data/ready.
// Ports: valid, data (source to sink), ready (sink to source).
// master = word source (reader), slave = word consumer.
interface fifo_sync_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_skid_buf2.sv
// 2-entry circular buffer holding words already read out of the FIFO.
// Latency: a pushed word is visible at o_head_data the following cycle.
// Backpressure: none internally; the caller never pushes into a full buffer.
// Ports: i_clk, i_rstn (sync, active-low), i_push/i_push_data, i_pop,
//        i_flush (priority over push/pop), o_head_data, o_count[1:0].
module fifo_skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (i_push) begin
                mem_d[tail_q] = i_push_data;
                tail_d        = ~tail_q;
            end
            if (i_pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; contents are only looked at when count != 0.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_head_data = mem_q[head_q];
    assign o_count     = count_q;

endmodule

// File: rtl/fifo_sync_reader.sv
// Drains fifo_sync and presents its words as a registered valid/ready stream.
// Latency: read at t, FIFO data at t+1, o_valid at t+2; 1 word/cycle sustained.
// Backpressure: reads are budgeted against a 2-entry buffer; never underruns.
// Ports: i_clk, i_rstn (sync, active-low); FIFO side o_fifo_rd, i_fifo_data,
//        i_fifo_status, i_fifo_error; stream side strm (valid/data/ready);
//        i_flush, o_level (buffered words), o_fifo_err (sticky FIFO error).
module fifo_sync_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    output logic                    o_fifo_rd,
    input  logic [DATA_WIDTH-1:0]   i_fifo_data,
    input  logic [ADDR_WIDTH+1:0]   i_fifo_status,
    input  logic                    i_fifo_error,
    fifo_sync_reader_if.master      strm,
    input  logic                    i_flush,
    output logic [1:0]              o_level,
    output logic                    o_fifo_err
);

    logic       infl_q, infl_d;
    logic       fifo_err_q, fifo_err_d;
    logic [1:0] occ;
    logic       pop;
    logic       drop;
    logic       capture;
    logic       fifo_empty;

    // Full and fill are informational; they never gate reads.
    logic unused_status;
    assign unused_status = ^{i_fifo_status[ADDR_WIDTH+1:ST_FILL_LSB],
                             i_fifo_status[ST_FULL]};

    assign fifo_empty = i_fifo_status[ST_EMPTY];
    assign pop        = strm.valid && strm.ready;

    // The FIFO updates empty on the same edge as its read pointer, so the
    // current-cycle flag is enough to keep back-to-back reads safe.
    assign o_fifo_rd = i_rstn && !fifo_empty && !i_flush
                       && can_issue(occ, infl_q, pop);

    // A flush on the cycle the in-flight word arrives drops that word.
    assign drop    = i_flush && infl_q;
    assign capture = infl_q && !drop;

    always_comb begin
        infl_d     = o_fifo_rd;
        fifo_err_d = i_flush ? 1'b0 : (fifo_err_q || i_fifo_error);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            infl_q     <= 1'b0;
            fifo_err_q <= 1'b0;
        end else begin
            infl_q     <= infl_d;
            fifo_err_q <= fifo_err_d;
        end
    end

    fifo_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (capture),
        .i_push_data (i_fifo_data),
        .i_pop       (pop),
        .i_flush     (i_flush),
        .o_head_data (strm.data),
        .o_count     (occ)
    );

    assign strm.valid = (occ != 2'd0);
    assign o_level    = occ;
    assign o_fifo_err = fifo_err_q;

endmodule

// File: tb/tb_fifo_sync_reader.sv
// Directed bench for fifo_sync_reader with a behavioural fifo_sync model.
module tb_fifo_sync_reader;

    logic        clk;
    logic        rstn;
    logic        rd;
    logic [7:0]  fdata;
    logic [10:0] status;
    logic        ferr;
    logic        flush;
    logic [1:0]  level;
    logic        err;
    logic        force_err;

    int vectors    = 0;
    int miscompares = 0;

    fifo_sync_reader_if #(.DATA_WIDTH(8)) strm ();

    fifo_sync_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (9)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .o_fifo_rd     (rd),
        .i_fifo_data   (fdata),
        .i_fifo_status (status),
        .i_fifo_error  (ferr),
        .strm          (strm),
        .i_flush       (flush),
        .o_level       (level),
        .o_fifo_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fifo_sync model: registered read data, empty/pointer on the same edge.
    logic [7:0] fmem [0:63];
    int         wrp = 0;
    int         rdp = 0;
    logic       uerr = 1'b0;
    logic [8:0] fill9;

    assign fill9  = 9'(wrp - rdp);
    assign status = {fill9, 1'b0, (wrp == rdp)};
    assign ferr   = uerr | force_err;

    always @(posedge clk) begin
        uerr <= rd && (wrp == rdp);
        if (rd && (wrp != rdp)) begin
            fdata <= fmem[rdp % 64];
            rdp   <= rdp + 1;
        end
    end

    task automatic push_word(input logic [7:0] w);
        fmem[wrp % 64] = w;
        wrp = wrp + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, last, acc, f;
        logic lvl_ok, fill_ok, rd_seen, err_hold;
        logic [7:0] exp5 [2];

        rstn = 1'b0; flush = 1'b0; force_err = 1'b0;
        strm.ready = 1'b0;

        // Reset with a non-empty FIFO.
        push_word(8'hA5);
        repeat (3) begin
            tick();
            chk("rst_rd",    32'(rd),    0);
            chk("rst_valid", 32'(strm.valid), 0);
            chk("rst_level", 32'(level), 0);
        end
        chk("rst_err", 32'(err), 0);

        // Single word.
        strm.ready = 1'b1;
        rstn = 1'b1;
        #1;
        chk("single_rd_t", 32'(rd), 1);
        tick();
        chk("single_rd_t1",    32'(rd), 0);
        chk("single_valid_t1", 32'(strm.valid), 0);
        tick();
        chk("single_valid_t2", 32'(strm.valid), 1);
        chk("single_data_t2",  32'(strm.data), 32'h A5);
        chk("single_level_t2", 32'(level), 1);
        tick();
        chk("single_valid_t3", 32'(strm.valid), 0);
        chk("single_fill",     32'(fill9), 0);
        chk("single_fifo_err", 32'(uerr), 0);

        // Streaming 16 words with ready held high.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        n = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (strm.valid) begin
                if (n < 16) chk("stream_data", 32'(strm.data), 32'(n));
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        chk("stream_count",   32'(n), 16);
        chk("stream_gapless", 32'(last - first + 1), 16);
        chk("stream_err",     32'(err), 0);

        // Back-pressure with ready pattern 1,0,0,1.
        for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
        acc = 0; lvl_ok = 1'b1; fill_ok = 1'b1;
        for (int c = 0; c < 200 && acc < 16; c++) begin
            strm.ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (level > 2'd2) lvl_ok = 1'b0;
            f = int'(fill9);
            if (f > 16 - acc || f + acc + 2 < 16) fill_ok = 1'b0;
            if (strm.valid && strm.ready) begin
                chk("bp_data", 32'(strm.data), 32'(8'h40 + acc));
                acc++;
            end
            tick();
        end
        chk("bp_count",    32'(acc), 16);
        chk("bp_level_ok", 32'(lvl_ok), 1);
        chk("bp_fill_ok",  32'(fill_ok), 1);
        strm.ready = 1'b1;
        tick(); tick();
        chk("bp_drained_valid", 32'(strm.valid), 0);
        chk("bp_drained_fill",  32'(fill9), 0);

        // Flush with one word buffered and one in flight.
        strm.ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h30 + i));
        #1;
        chk("flush_rd_c0", 32'(rd), 1);
        tick();
        chk("flush_level_c1", 32'(level), 0);
        tick();
        chk("flush_level_c2", 32'(level), 1);
        chk("flush_rd_c2",    32'(rd), 0);
        flush = 1'b1;
        #1;
        chk("flush_rd_blocked", 32'(rd), 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(strm.valid), 0);
        chk("flush_level", 32'(level), 0);
        strm.ready = 1'b1;
        exp5[0] = 8'h32; exp5[1] = 8'h33;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (strm.valid) begin
                if (n < 2) chk("flush_resume_data", 32'(strm.data), 32'(exp5[n]));
                n++;
            end
        end
        chk("flush_resume_count", 32'(n), 2);

        // Empty FIFO: no reads; then a one-cycle FIFO error.
        rd_seen = 1'b0;
        repeat (20) begin
            tick();
            if (rd) rd_seen = 1'b1;
        end
        chk("empty_no_rd",    32'(rd_seen), 0);
        chk("empty_no_under", 32'(uerr), 0);
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        chk("err_set", 32'(err), 1);
        err_hold = 1'b1;
        repeat (5) begin
            tick();
            if (err !== 1'b1) err_hold = 1'b0;
        end
        chk("err_sticky", 32'(err_hold), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("err_cleared", 32'(err), 0);
        tick();
        chk("err_stays_clear", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
